// File: rtl/apb_package.sv
// ---------------------------------------------------------------------------
// apb_package
//   Shared APB bundle types plus the SPI register-window definitions.
//   master_s_type : bridge -> slave request fields (paddr/pwrite/pwdata/
//                   penable/pprot/pstrb)
//   slave_s_type  : slave -> bridge response fields (prdata/pready/pslverr)
//   spi_reg_e     : word offsets inside the 8-word SPI window (paddr[4:2])
//   ST_* / ISR_*  : bit positions inside the STATUS and ISR words
// ---------------------------------------------------------------------------
package apb_package;

  typedef struct packed {
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic        penable;
    logic [2:0]  pprot;
    logic [3:0]  pstrb;
  } master_s_type;

  typedef struct packed {
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
  } slave_s_type;

  typedef enum logic [2:0] {
    REG_CTRL   = 3'd0,
    REG_DIV    = 3'd1,
    REG_STATUS = 3'd2,
    REG_TXDATA = 3'd3,
    REG_RXDATA = 3'd4,
    REG_IER    = 3'd5,
    REG_ISR    = 3'd6,
    REG_SSCTRL = 3'd7
  } spi_reg_e;

  // STATUS word layout
  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_FULL  = 2;
  localparam int ST_RX_EMPTY = 3;
  localparam int ST_BUSY     = 4;
  localparam int ST_RX_OVF   = 5;
  localparam int ST_TX_CNT   = 8;   // [10:8]
  localparam int ST_RX_CNT   = 12;  // [14:12]

  // ISR word layout (raw interrupt sources)
  localparam int ISR_TX_EMPTY = 0;
  localparam int ISR_RX_NE    = 1;
  localparam int ISR_RX_OVF   = 2;

endpackage

// File: rtl/apb_spi_regif_fifo.sv
// ---------------------------------------------------------------------------
// spi_sync_fifo
//   Single-clock first-word-fall-through byte FIFO used for the SPI TX and RX
//   paths.
//   clk/rst_n  : clock, async active-low reset (pointers and count cleared)
//   push/din   : write strobe and data; accepted when not full, or when full
//                and a pop happens in the same cycle
//   pop        : consume head; ignored when empty
//   dout       : current head (0 while empty)
//   full/empty : occupancy flags from the registered count
//   count      : occupancy 0..DEPTH
// ---------------------------------------------------------------------------
module spi_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt_reg == '0);
  assign full    = (cnt_reg == CNT_W'(DEPTH));
  assign count   = cnt_reg;
  assign do_pop  = pop && !empty;
  // When full, the slot being written is the one the same-cycle pop frees.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  // Power-of-two depth: pointers wrap naturally at PTR_W bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_reg <= cnt_reg + CNT_W'(1);
        2'b01:   cnt_reg <= cnt_reg - CNT_W'(1);
        default: cnt_reg <= cnt_reg;
      endcase
    end
  end

endmodule

// File: rtl/apb_spi_regif.sv
// ---------------------------------------------------------------------------
// apb_spi_regif
//   APB register slave for the SPI peripheral. Every transfer takes exactly
//   one wait state (IDLE -> WAIT -> RESP); all side effects commit in RESP.
//   apb_clk, rst_n            : clock, async active-low reset
//   spi_psel, apb_spi_out     : APB request from the bridge
//   apb_spi_in                : prdata/pready/pslverr response
//   tx_data/tx_valid/tx_ready : TX FIFO head towards the shift core
//   rx_data/rx_valid          : received byte push from the shift core
//   cfg_en/cpol/cpha/lsb/div  : configuration outputs (CTRL, DIV)
//   ss_n                      : slave select (SSCTRL[0], resets to 1)
//   busy                      : core status, visible in STATUS only
//   irq                       : registered |(ISR & IER)
// ---------------------------------------------------------------------------
module apb_spi_regif
  import apb_package::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0001_0100,
  parameter int          FIFO_DEPTH = 4,
  parameter int          CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic         apb_clk,
  input  logic         rst_n,
  input  logic         spi_psel,
  input  master_s_type apb_spi_out,
  output slave_s_type  apb_spi_in,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic         cfg_en,
  output logic         cfg_cpol,
  output logic         cfg_cpha,
  output logic         cfg_lsb,
  output logic [15:0]  cfg_div,
  output logic         ss_n,
  input  logic         busy,
  output logic         irq
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} apb_state_e;

  apb_state_e state_reg, state_next;

  logic [3:0]  ctrl_reg;
  logic [15:0] div_reg;
  logic [2:0]  ier_reg;
  logic        ss_reg;
  logic        rx_ovf_reg;
  logic        irq_reg;

  logic             tx_full, tx_empty, rx_full, rx_empty;
  logic [CNT_W-1:0] tx_cnt, rx_cnt;
  logic [7:0]       rx_head;

  spi_reg_e    reg_sel;
  logic        in_window;
  logic        acc_err;
  logic        commit;
  logic        wr_en, rd_en;
  logic        tx_push, tx_pop, rx_push, rx_pop;
  logic        rx_ovf_set, isr_w1c;
  logic [31:0] status_word;
  logic [2:0]  isr_raw;
  logic [31:0] rd_word;

  // pprot/pstrb, sub-word address bits and high write data are don't-care.
  logic unused_inputs;
  assign unused_inputs = ^{apb_spi_out.pprot, apb_spi_out.pstrb,
                           apb_spi_out.paddr[1:0], apb_spi_out.pwdata[31:16]};

  // ---------------- decode / error ----------------
  assign in_window = (apb_spi_out.paddr[31:5] == BASE_ADDR[31:5]);
  assign reg_sel   = spi_reg_e'(apb_spi_out.paddr[4:2]);

  always_comb begin
    acc_err = 1'b0;
    if (!in_window) begin
      acc_err = 1'b1;
    end else if (apb_spi_out.pwrite) begin
      if (reg_sel == REG_STATUS || reg_sel == REG_RXDATA) acc_err = 1'b1;
      if (reg_sel == REG_TXDATA && tx_full)               acc_err = 1'b1;
    end else begin
      if (reg_sel == REG_RXDATA && rx_empty)              acc_err = 1'b1;
    end
  end

  // A select dropped during RESP aborts the transfer without side effects.
  assign commit  = (state_reg == ST_RESP) && spi_psel && !acc_err;
  assign wr_en   = commit && apb_spi_out.pwrite;
  assign rd_en   = commit && !apb_spi_out.pwrite;
  assign tx_push = wr_en && (reg_sel == REG_TXDATA);
  assign rx_pop  = rd_en && (reg_sel == REG_RXDATA);
  assign isr_w1c = wr_en && (reg_sel == REG_ISR) && apb_spi_out.pwdata[ISR_RX_OVF];
  assign tx_pop  = tx_valid && tx_ready;
  assign rx_push = rx_valid;
  // A pop in the same cycle makes room, so only an unmatched push overflows.
  assign rx_ovf_set = rx_valid && rx_full && !rx_pop;

  // ---------------- FIFOs ----------------
  spi_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_tx_fifo (
    .clk   (apb_clk),
    .rst_n (rst_n),
    .push  (tx_push),
    .din   (apb_spi_out.pwdata[7:0]),
    .pop   (tx_pop),
    .dout  (tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_cnt)
  );

  spi_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_rx_fifo (
    .clk   (apb_clk),
    .rst_n (rst_n),
    .push  (rx_push),
    .din   (rx_data),
    .pop   (rx_pop),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_cnt)
  );

  assign tx_valid = !tx_empty;

  // ---------------- read views ----------------
  always_comb begin
    status_word = '0;
    status_word[ST_TX_FULL]               = tx_full;
    status_word[ST_TX_EMPTY]              = tx_empty;
    status_word[ST_RX_FULL]               = rx_full;
    status_word[ST_RX_EMPTY]              = rx_empty;
    status_word[ST_BUSY]                  = busy;
    status_word[ST_RX_OVF]                = rx_ovf_reg;
    status_word[ST_TX_CNT +: 3]           = 3'(tx_cnt);
    status_word[ST_RX_CNT +: 3]           = 3'(rx_cnt);
  end

  always_comb begin
    isr_raw               = '0;
    isr_raw[ISR_TX_EMPTY] = tx_empty;
    isr_raw[ISR_RX_NE]    = !rx_empty;
    isr_raw[ISR_RX_OVF]   = rx_ovf_reg;
  end

  always_comb begin
    rd_word = '0;
    case (reg_sel)
      REG_CTRL:   rd_word = {28'd0, ctrl_reg};
      REG_DIV:    rd_word = {16'd0, div_reg};
      REG_STATUS: rd_word = status_word;
      REG_TXDATA: rd_word = '0;
      REG_RXDATA: rd_word = {24'd0, rx_head};
      REG_IER:    rd_word = {29'd0, ier_reg};
      REG_ISR:    rd_word = {29'd0, isr_raw};
      REG_SSCTRL: rd_word = {31'd0, ss_reg};
      default:    rd_word = '0;
    endcase
  end

  // ---------------- APB FSM ----------------
  always_ff @(posedge apb_clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next         = state_reg;
    apb_spi_in.pready  = 1'b0;
    apb_spi_in.pslverr = 1'b0;
    apb_spi_in.prdata  = '0;
    case (state_reg)
      ST_IDLE: if (spi_psel && !apb_spi_out.penable) state_next = ST_WAIT;
      ST_WAIT: state_next = spi_psel ? ST_RESP : ST_IDLE;
      ST_RESP: begin
        state_next         = ST_IDLE;
        apb_spi_in.pready  = 1'b1;
        apb_spi_in.pslverr = acc_err;
        if (!acc_err && !apb_spi_out.pwrite) apb_spi_in.prdata = rd_word;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------- registers / IRQ ----------------
  always_ff @(posedge apb_clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_reg   <= '0;
      div_reg    <= '0;
      ier_reg    <= '0;
      ss_reg     <= 1'b1;
      rx_ovf_reg <= 1'b0;
      irq_reg    <= 1'b0;
    end else begin
      if (wr_en) begin
        case (reg_sel)
          REG_CTRL:   ctrl_reg <= apb_spi_out.pwdata[3:0];
          REG_DIV:    div_reg  <= apb_spi_out.pwdata[15:0];
          REG_IER:    ier_reg  <= apb_spi_out.pwdata[2:0];
          REG_SSCTRL: ss_reg   <= apb_spi_out.pwdata[0];
          default:    ;
        endcase
      end
      // New overflow beats a concurrent clear so no event is lost.
      if (rx_ovf_set)   rx_ovf_reg <= 1'b1;
      else if (isr_w1c) rx_ovf_reg <= 1'b0;
      irq_reg <= |(isr_raw & ier_reg);
    end
  end

  assign cfg_en   = ctrl_reg[0];
  assign cfg_cpol = ctrl_reg[1];
  assign cfg_cpha = ctrl_reg[2];
  assign cfg_lsb  = ctrl_reg[3];
  assign cfg_div  = div_reg;
  assign ss_n     = ss_reg;
  assign irq      = irq_reg;

endmodule

// File: tb/tb_apb_spi_regif.sv
module tb_apb_spi_regif;
  import apb_package::*;

  localparam logic [31:0] BASE = 32'h0001_0100;

  logic         apb_clk = 1'b0;
  logic         rst_n   = 1'b0;
  logic         spi_psel = 1'b0;
  master_s_type m;
  slave_s_type  s;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready = 1'b0;
  logic [7:0]   rx_data  = 8'h00;
  logic         rx_valid = 1'b0;
  logic         cfg_en, cfg_cpol, cfg_cpha, cfg_lsb;
  logic [15:0]  cfg_div;
  logic         ss_n;
  logic         busy = 1'b0;
  logic         irq;

  int tests = 0;
  int fails = 0;

  always #5 apb_clk = ~apb_clk;

  apb_spi_regif dut (
    .apb_clk     (apb_clk),
    .rst_n       (rst_n),
    .spi_psel    (spi_psel),
    .apb_spi_out (m),
    .apb_spi_in  (s),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .cfg_en      (cfg_en),
    .cfg_cpol    (cfg_cpol),
    .cfg_cpha    (cfg_cpha),
    .cfg_lsb     (cfg_lsb),
    .cfg_div     (cfg_div),
    .ss_n        (ss_n),
    .busy        (busy),
    .irq         (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One complete APB transfer; reports data, error and wait cycles seen.
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int waits);
    int guard;
    @(posedge apb_clk); #1;
    m.paddr = addr; m.pwrite = wr; m.pwdata = wdata; m.penable = 1'b0; spi_psel = 1'b1;
    @(posedge apb_clk); #1;
    m.penable = 1'b1;
    waits = 0; guard = 0;
    @(negedge apb_clk);
    while (s.pready !== 1'b1 && guard < 8) begin
      waits++; guard++;
      @(negedge apb_clk);
    end
    check("pready_seen", {31'd0, s.pready}, 32'd1);
    rdata = s.prdata;
    err   = s.pslverr;
    @(posedge apb_clk); #1;
    spi_psel = 1'b0; m.penable = 1'b0;
    $display("[TB] %s addr=0x%08h wdata=0x%08h rdata=0x%08h err=%0b waits=%0d",
             wr ? "WR" : "RD", addr, wdata, rdata, err, waits);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          w;

    m = '0;
    repeat (2) @(posedge apb_clk);
    #1 rst_n = 1'b1;

    // ---- reset in the middle of a transfer ----
    apb_xfer(1'b1, BASE + 32'h1C, 32'h0, rd, er, w);
    check("ssctrl_clear_ssn", {31'd0, ss_n}, 32'd0);
    @(posedge apb_clk); #1;
    m.paddr = BASE; m.pwrite = 1'b1; m.pwdata = 32'h5; m.penable = 1'b0; spi_psel = 1'b1;
    @(posedge apb_clk); #1;
    m.penable = 1'b1;
    @(negedge apb_clk);
    rst_n = 1'b0;
    #1;
    check("rst_pready", {31'd0, s.pready}, 32'd0);
    check("rst_ssn", {31'd0, ss_n}, 32'd1);
    @(posedge apb_clk); #1;
    check("rst_pready_hold", {31'd0, s.pready}, 32'd0);
    spi_psel = 1'b0; m.penable = 1'b0;
    @(posedge apb_clk); #1 rst_n = 1'b1;
    apb_xfer(1'b0, BASE + 32'h08, 32'h0, rd, er, w);
    check("rst_status", rd, 32'h0000_000A);
    apb_xfer(1'b0, BASE, 32'h0, rd, er, w);
    check("rst_ctrl_no_commit", rd, 32'h0);

    // ---- CTRL / DIV ----
    apb_xfer(1'b1, BASE, 32'hF, rd, er, w);
    check("ctrl_wr_waits", 32'(w), 32'd1);
    check("ctrl_wr_err", {31'd0, er}, 32'd0);
    apb_xfer(1'b1, BASE + 32'h04, 32'h0010, rd, er, w);
    check("div_wr_waits", 32'(w), 32'd1);
    apb_xfer(1'b0, BASE, 32'h0, rd, er, w);
    check("ctrl_rd", rd, 32'hF);
    check("ctrl_rd_waits", 32'(w), 32'd1);
    apb_xfer(1'b0, BASE + 32'h04, 32'h0, rd, er, w);
    check("div_rd", rd, 32'h10);
    check("cfg_bits", {27'd0, cfg_lsb, cfg_cpha, cfg_cpol, cfg_en, 1'b0}, 32'h1E);
    check("cfg_div", {16'd0, cfg_div}, 32'h10);

    // ---- TX FIFO ----
    for (int i = 0; i < 4; i++) begin
      apb_xfer(1'b1, BASE + 32'h0C, 32'hA1 + 32'(i), rd, er, w);
      check("tx_push_err", {31'd0, er}, 32'd0);
    end
    apb_xfer(1'b1, BASE + 32'h0C, 32'hA5, rd, er, w);
    check("tx_full_err", {31'd0, er}, 32'd1);
    apb_xfer(1'b0, BASE + 32'h08, 32'h0, rd, er, w);
    check("tx_full_status", rd, 32'h0000_0409);
    apb_xfer(1'b0, BASE + 32'h0C, 32'h0, rd, er, w);
    check("txdata_rd_val", rd, 32'h0);
    check("txdata_rd_err", {31'd0, er}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge apb_clk);
      check("tx_valid", {31'd0, tx_valid}, 32'd1);
      check("tx_order", {24'd0, tx_data}, 32'hA1 + 32'(i));
      $display("[TB] TX pop byte=0x%02h", tx_data);
      tx_ready = 1'b1;
      @(posedge apb_clk); #1 tx_ready = 1'b0;
    end
    @(negedge apb_clk);
    check("tx_drained", {31'd0, tx_valid}, 32'd0);

    // ---- RX FIFO with overflow ----
    for (int i = 0; i < 5; i++) begin
      @(posedge apb_clk); #1;
      rx_data = 8'h11 + 8'(i); rx_valid = 1'b1;
      $display("[TB] RX push byte=0x%02h", rx_data);
      @(posedge apb_clk); #1 rx_valid = 1'b0;
    end
    apb_xfer(1'b0, BASE + 32'h08, 32'h0, rd, er, w);
    check("rx_full_status", rd, 32'h0000_4026);
    apb_xfer(1'b0, BASE + 32'h18, 32'h0, rd, er, w);
    check("isr_raw", rd, 32'h7);
    for (int i = 0; i < 4; i++) begin
      apb_xfer(1'b0, BASE + 32'h10, 32'h0, rd, er, w);
      check("rx_data", rd, 32'h11 + 32'(i));
      check("rx_err", {31'd0, er}, 32'd0);
    end
    apb_xfer(1'b0, BASE + 32'h10, 32'h0, rd, er, w);
    check("rx_empty_err", {31'd0, er}, 32'd1);
    check("rx_empty_prdata", rd, 32'h0);

    // ---- IRQ ----
    check("irq_idle", {31'd0, irq}, 32'd0);
    apb_xfer(1'b1, BASE + 32'h14, 32'h4, rd, er, w);
    check("irq_latency", {31'd0, irq}, 32'd0);
    @(posedge apb_clk); #1;
    check("irq_set", {31'd0, irq}, 32'd1);
    apb_xfer(1'b1, BASE + 32'h18, 32'h4, rd, er, w);
    check("irq_hold", {31'd0, irq}, 32'd1);
    @(posedge apb_clk); #1;
    check("irq_clr", {31'd0, irq}, 32'd0);

    // ---- error accesses without side effects ----
    apb_xfer(1'b0, 32'h0001_0120, 32'h0, rd, er, w);
    check("oow_err", {31'd0, er}, 32'd1);
    check("oow_prdata", rd, 32'h0);
    apb_xfer(1'b1, BASE + 32'h08, 32'hFFFF_FFFF, rd, er, w);
    check("status_wr_err", {31'd0, er}, 32'd1);
    apb_xfer(1'b1, 32'h0001_0120, 32'h0, rd, er, w);
    check("oow_wr_err", {31'd0, er}, 32'd1);
    apb_xfer(1'b0, BASE + 32'h08, 32'h0, rd, er, w);
    check("status_final", rd, 32'h0000_000A);
    apb_xfer(1'b0, BASE, 32'h0, rd, er, w);
    check("ctrl_unchanged", rd, 32'hF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
